// File: rtl/ct_f_spsram_pkg.sv
// ct_f_spsram_pkg: shared init-FSM states and geometry helpers for the parametrised SRAM model.
package ct_f_spsram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } init_state_e;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int lane_num(input int dw, input int gran);
        return dw / gran;
    endfunction

    function automatic int bank_bits(input int banks);
        return clog2(banks);
    endfunction

endpackage

// File: rtl/ct_f_spsram_bank.sv
// ct_f_spsram_bank: one bank of the SRAM, built from per-lane arrays with a
// registered read port that only updates on a read.
module ct_f_spsram_bank
    import ct_f_spsram_pkg::*;
#(
    parameter int AW   = 12,
    parameter int DW   = 84,
    parameter int GRAN = 1,
    localparam int LN  = lane_num(DW, GRAN)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          cen_i,
    input  logic          gwen_i,
    input  logic [LN-1:0] wen_i,
    input  logic [AW-1:0] a_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [LN-1:0] we;
    logic [DW-1:0] rd_w;
    logic [DW-1:0] q_q;

    assign we = {LN{!cen_i && !gwen_i}} & ~wen_i;

    for (genvar k = 0; k < LN; k++) begin : g_lane
        logic [GRAN-1:0] mem [1 << AW];
        always_ff @(posedge clk_i) begin
            if (we[k]) mem[a_i] <= d_i[k*GRAN +: GRAN];
        end
        assign rd_w[k*GRAN +: GRAN] = mem[a_i];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) q_q <= '0;
        else if (!cen_i && gwen_i) q_q <= rd_w;
    end

    assign q_o = q_q;

endmodule

// File: rtl/ct_f_spsram_param.sv
// ct_f_spsram_param: parametrised single-port SRAM with lane write mask, banking,
// optional output register, read-data hold and post-reset init sweep.
module ct_f_spsram_param
    import ct_f_spsram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 84,
    parameter int                    WEN_GRAN   = 1,
    parameter int                    BANK_NUM   = 1,
    parameter int                    OUT_REG    = 0,
    parameter int                    INIT_EN    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    localparam int                   LN         = lane_num(DATA_WIDTH, WEN_GRAN)
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [LN-1:0]         WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  BUSY,
    output logic                  INIT_DONE
);

    localparam int                  BB      = bank_bits(BANK_NUM);
    localparam int                  SW      = (BB > 0) ? BB : 1;
    localparam int                  BAW     = ADDR_WIDTH - BB;
    localparam logic [ADDR_WIDTH:0] LAST    = (ADDR_WIDTH + 1)'((1 << ADDR_WIDTH) - 1);
    localparam logic                INIT_ON = (INIT_EN != 0);

    if (DATA_WIDTH % WEN_GRAN != 0) begin : g_gran_chk
        $error("DATA_WIDTH must be a multiple of WEN_GRAN");
    end
    if ((BANK_NUM & (BANK_NUM - 1)) != 0) begin : g_bank_chk
        $error("BANK_NUM must be a power of 2");
    end

    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  sweep, busy, acc_cen, acc_gwen, rd;
    logic [ADDR_WIDTH-1:0] acc_a;
    logic [LN-1:0]         acc_wen;
    logic [DATA_WIDTH-1:0] acc_d, rd_mux;
    logic [SW-1:0]         bsel, sel_q;
    logic [DATA_WIDTH-1:0] bq [1 << SW];

    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter parks on the last entry instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  state_d = INIT_ON ? SWEEP : DONE;
            SWEEP: begin
                state_d = (cnt_q == LAST) ? DONE : SWEEP;
                cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + (ADDR_WIDTH + 1)'(1);
            end
            default: ;
        endcase
    end

    assign sweep     = (state_q == SWEEP);
    assign busy      = sweep || (state_q == IDLE && INIT_ON);
    assign BUSY      = busy;
    assign INIT_DONE = (state_q == DONE) || (state_q == IDLE && !INIT_ON);

    assign acc_a    = sweep ? cnt_q[ADDR_WIDTH-1:0] : A;
    assign acc_cen  = sweep ? 1'b0 : (busy || CEN);
    assign acc_gwen = !sweep && GWEN;
    assign acc_wen  = sweep ? '0 : WEN;
    assign acc_d    = sweep ? INIT_VAL : D;
    assign rd       = !acc_cen && acc_gwen;

    if (BB > 0) begin : g_bsel
        assign bsel = acc_a[ADDR_WIDTH-1 -: SW];
    end else begin : g_nobsel
        assign bsel = '0;
    end

    for (genvar b = 0; b < (1 << SW); b++) begin : g_bank
        if (b < BANK_NUM) begin : g_on
            ct_f_spsram_bank #(
                .AW   (BAW),
                .DW   (DATA_WIDTH),
                .GRAN (WEN_GRAN)
            ) u_bank (
                .clk_i   (CLK),
                .rst_n_i (cpurst_b),
                .cen_i   (acc_cen || (bsel != SW'(b))),
                .gwen_i  (acc_gwen),
                .wen_i   (acc_wen),
                .a_i     (acc_a[BAW-1:0]),
                .d_i     (acc_d),
                .q_o     (bq[b])
            );
        end else begin : g_off
            assign bq[b] = '0;
        end
    end

    // Select only moves on a read, so the mux output holds between reads.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) sel_q <= '0;
        else if (rd) sel_q <= bsel;
    end

    assign rd_mux = bq[sel_q];

    if (OUT_REG != 0) begin : g_oreg
        logic                  rd_q;
        logic [DATA_WIDTH-1:0] q_q;
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
                rd_q <= 1'b0;
                q_q  <= '0;
            end else begin
                rd_q <= rd;
                if (rd_q) q_q <= rd_mux;
            end
        end
        assign Q = q_q;
    end else begin : g_noreg
        assign Q = rd_mux;
    end

endmodule
